// File: rtl/radial_dist_sq_pkg.sv
// Shared FSM encoding and width helpers for the radial_dist_sq block.
package radial_dist_sq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Width of a squared coordinate.
  function automatic int sq_width(input int coord_w);
    return 2 * coord_w;
  endfunction

  // Width of the sum of two squares, before saturation.
  function automatic int sum_width(input int coord_w);
    return 2 * coord_w + 1;
  endfunction

endpackage

// File: rtl/radial_dist_sq_serial_squarer.sv
// Shift-add squarer: one operand bit per cycle, W cycles from start to done.
module serial_squarer
  import radial_dist_sq_pkg::*;
#(
  parameter  int W    = 10,
  localparam int SQ_W = sq_width(W)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [W-1:0]    operand,
  output logic [SQ_W-1:0] result,
  output logic            done
);

  localparam int CNT_W = $clog2(W + 1);

  logic [SQ_W-1:0]  mcand;
  logic [W-1:0]     mult;
  logic [CNT_W-1:0] count;
  logic             active;

  // The start cycle already consumes operand bit 0, so the product is
  // complete after W-1 further iterations and done rises W cycles after start.
  // NOTE: state registers take non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      mcand  <= '0;
      mult   <= '0;
      count  <= '0;
      active <= 1'b0;
    end else if (start) begin
      result <= operand[0] ? SQ_W'(operand) : '0;
      mcand  <= SQ_W'(operand) << 1;
      mult   <= operand >> 1;
      count  <= CNT_W'(1);
      active <= 1'b1;
    end else if (active && count != CNT_W'(W)) begin
      if (mult[0]) result <= result + mcand;
      mcand <= mcand << 1;
      mult  <= mult >> 1;
      count <= count + CNT_W'(1);
    end
  end

  assign done = active && (count == CNT_W'(W));

endmodule

// File: rtl/radial_dist_sq.sv
// Incremental (x-cx)^2+(y-cy)^2 generator tracking the VGA scan position.
// Optional macro DIST_SQ_OUTREG_EN registers dist_sq/dist_valid from next-state values.
module radial_dist_sq
  import radial_dist_sq_pkg::*;
#(
  parameter int COORD_W   = 10,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic                 line_end,
  input  logic                 pix_en,
  input  logic [COORD_W-1:0]   center_x,
  input  logic [COORD_W-1:0]   center_y,
  output logic [OUT_WIDTH-1:0] dist_sq,
  output logic                 dist_valid,
  output logic                 busy
);

  localparam int SQ_W  = sq_width(COORD_W);
  localparam int SUM_W = sum_width(COORD_W);

  state_t              state, state_d;
  logic                phase, phase_d;      // 0: squaring cx, 1: squaring cy
  logic [COORD_W-1:0]  cx, cx_d, cy, cy_d;
  logic [SQ_W-1:0]     cx2, cx2_d, dx2, dx2_d, dy2, dy2_d;
  logic [COORD_W:0]    dx, dx_d, dy, dy_d;  // two's complement offsets

  logic                sq_start;
  logic [COORD_W-1:0]  sq_operand;
  logic [SQ_W-1:0]     sq_result;
  logic                sq_done;

  // (d+1)^2 = d^2 + 2d + 1, with d sign-extended to the square width.
  function automatic logic [SQ_W-1:0] step_sq(input logic [COORD_W:0] d,
                                              input logic [SQ_W-1:0]  d2);
    logic [SQ_W-1:0] d_ext;
    d_ext = {{(SQ_W - COORD_W - 1){d[COORD_W]}}, d};
    return d2 + (d_ext << 1) + SQ_W'(1);
  endfunction

  function automatic logic [OUT_WIDTH-1:0] saturate(input logic [SQ_W-1:0] a,
                                                    input logic [SQ_W-1:0] b);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b);
    return (|sum[SUM_W-1:OUT_WIDTH]) ? {OUT_WIDTH{1'b1}} : sum[OUT_WIDTH-1:0];
  endfunction

  serial_squarer #(.W(COORD_W)) u_squarer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (sq_start),
    .operand (sq_operand),
    .result  (sq_result),
    .done    (sq_done)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state;
    phase_d    = phase;
    cx_d       = cx;
    cy_d       = cy;
    cx2_d      = cx2;
    dx_d       = dx;
    dx2_d      = dx2;
    dy_d       = dy;
    dy2_d      = dy2;
    sq_start   = 1'b0;
    sq_operand = center_x;

    if (frame_start) begin
      state_d  = ST_CALC;
      phase_d  = 1'b0;
      cx_d     = center_x;
      cy_d     = center_y;
      sq_start = 1'b1;
    end else begin
      case (state)
        ST_CALC: begin
          if (sq_done && !phase) begin
            cx2_d      = sq_result;
            phase_d    = 1'b1;
            sq_start   = 1'b1;
            sq_operand = cy;
          end else if (sq_done) begin
            state_d = ST_RUN;
            dx_d    = -{1'b0, cx};
            dx2_d   = cx2;
            dy_d    = -{1'b0, cy};
            dy2_d   = sq_result;
          end
        end
        ST_RUN: begin
          // line_end takes priority; a coincident pix_en is dropped.
          if (line_end) begin
            dy2_d = step_sq(dy, dy2);
            dy_d  = dy + (COORD_W + 1)'(1);
            dx_d  = -{1'b0, cx};
            dx2_d = cx2;
          end else if (pix_en) begin
            dx2_d = step_sq(dx, dx2);
            dx_d  = dx + (COORD_W + 1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      phase <= 1'b0;
      cx    <= '0;
      cy    <= '0;
      cx2   <= '0;
      dx    <= '0;
      dx2   <= '0;
      dy    <= '0;
      dy2   <= '0;
      busy  <= 1'b0;
`ifdef DIST_SQ_OUTREG_EN
      dist_sq    <= '0;
      dist_valid <= 1'b0;
`endif
    end else begin
      state <= state_d;
      phase <= phase_d;
      cx    <= cx_d;
      cy    <= cy_d;
      cx2   <= cx2_d;
      dx    <= dx_d;
      dx2   <= dx2_d;
      dy    <= dy_d;
      dy2   <= dy2_d;
      busy  <= (state_d == ST_CALC);
`ifdef DIST_SQ_OUTREG_EN
      dist_sq    <= saturate(dx2_d, dy2_d);
      dist_valid <= (state_d == ST_RUN);
`endif
    end
  end

`ifndef DIST_SQ_OUTREG_EN
  assign dist_sq    = saturate(dx2, dy2);
  assign dist_valid = (state == ST_RUN);
`endif

endmodule

// File: tb/tb_radial_dist_sq.sv
// Self-checking bench for radial_dist_sq: directed scenarios plus random scans vs. a coordinate model.
module tb_radial_dist_sq;

  localparam int MAX_OUT = 65535;
  localparam int CALC_CYCLES = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        line_end = 1'b0;
  logic        pix_en = 1'b0;
  logic [9:0]  center_x = '0;
  logic [9:0]  center_y = '0;
  logic [15:0] dist_sq;
  logic        dist_valid;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Reference model: plain scan coordinates and a CALC countdown.
  int m_cx, m_cy, m_x, m_y, m_calc;
  bit m_run;

  radial_dist_sq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .line_end    (line_end),
    .pix_en      (pix_en),
    .center_x    (center_x),
    .center_y    (center_y),
    .dist_sq     (dist_sq),
    .dist_valid  (dist_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic int exp_dist();
    int d;
    d = (m_x - m_cx) * (m_x - m_cx) + (m_y - m_cy) * (m_y - m_cy);
    return (d > MAX_OUT) ? MAX_OUT : d;
  endfunction

  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Drive one cycle of strobes, clock it, and advance the model.
  task automatic cycle(input bit fs, input bit le, input bit pe, input int ncx, input int ncy);
    frame_start = fs;
    line_end    = le;
    pix_en      = pe;
    center_x    = 10'(ncx);
    center_y    = 10'(ncy);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    line_end    = 1'b0;
    pix_en      = 1'b0;
    if (fs) begin
      m_cx = ncx; m_cy = ncy; m_calc = CALC_CYCLES; m_run = 1'b0;
    end else if (m_calc > 0) begin
      m_calc--;
      if (m_calc == 0) begin
        m_run = 1'b1; m_x = 0; m_y = 0;
      end
    end else if (m_run) begin
      if (le) begin
        m_y++; m_x = 0;
      end else if (pe) begin
        m_x++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // Counts cycles with busy high, bounded so a stuck DUT cannot hang the run.
  task automatic wait_calc(output int n);
    n = 0;
    while (busy && n < 2 * CALC_CYCLES) begin
      n++;
      cycle(1'b0, 1'b0, 1'b0, 0, 0);
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    m_run = 1'b0; m_calc = 0;
    #3 rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 3, 4);
    wait_calc(n);
    cycle(1'b0, 1'b0, 1'b1, 0, 0);
    cycle(1'b1, 1'b0, 1'b0, 7, 9);
    idle(5);
    #2 rst_n = 1'b0;
    m_run = 1'b0; m_calc = 0;
    #1;
    total++;
    if (dist_sq !== 16'd0 || dist_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: dist_sq=%0d valid=%b busy=%b, required 0/0/0", dist_sq, dist_valid, busy);
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1'b0, i[0], 1'b1, 5, 5);
    total++;
    if (dist_sq !== 16'd0 || dist_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: dist_sq=%0d valid=%b busy=%b, required 0/0/0", dist_sq, dist_valid, busy);
    end
  endtask

  task automatic test_basic();
    int n;
    cycle(1'b1, 1'b0, 1'b0, 3, 4);
    wait_calc(n);
    total++;
    if (n != CALC_CYCLES) begin
      bad++;
      $display("FAIL busy_len: got %0d cycles, required %0d", n, CALC_CYCLES);
    end
    total++;
    if (dist_sq !== 16'd25 || dist_valid !== 1'b1) begin
      bad++;
      $display("FAIL origin_3_4: dist_sq=%0d valid=%b, required 25/1", dist_sq, dist_valid);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 0, 0);
    total++;
    if (dist_sq !== 16'd16) begin
      bad++;
      $display("FAIL pix3: dist_sq=%0d, required 16", dist_sq);
    end
    cycle(1'b0, 1'b1, 1'b0, 0, 0);
    total++;
    if (dist_sq !== 16'd18) begin
      bad++;
      $display("FAIL line1: dist_sq=%0d, required 18", dist_sq);
    end
  endtask

  task automatic test_line_end();
    int n;
    cycle(1'b1, 1'b0, 1'b0, 3, 4);
    wait_calc(n);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 0, 0);
    cycle(1'b0, 1'b0, 1'b1, 0, 0);
    cycle(1'b0, 1'b0, 1'b1, 0, 0);
    total++;
    if (dist_sq !== 16'd2) begin
      bad++;
      $display("FAIL x2_y3: dist_sq=%0d, required 2", dist_sq);
    end
    cycle(1'b0, 1'b1, 1'b1, 0, 0);
    total++;
    if (dist_sq !== 16'd9) begin
      bad++;
      $display("FAIL line_end_wins: dist_sq=%0d, required 9", dist_sq);
    end
    idle(3);
    total++;
    if (dist_sq !== 16'd9 || dist_valid !== 1'b1) begin
      bad++;
      $display("FAIL hold: dist_sq=%0d valid=%b, required 9/1", dist_sq, dist_valid);
    end
  endtask

  task automatic test_saturation();
    int n;
    cycle(1'b1, 1'b0, 1'b0, 0, 0);
    wait_calc(n);
    total++;
    if (dist_sq !== 16'd0) begin
      bad++;
      $display("FAIL origin_0_0: dist_sq=%0d, required 0", dist_sq);
    end
    for (int i = 0; i < 255; i++) cycle(1'b0, 1'b0, 1'b1, 0, 0);
    total++;
    if (dist_sq !== 16'd65025) begin
      bad++;
      $display("FAIL x255: dist_sq=%0d, required 65025", dist_sq);
    end
    cycle(1'b0, 1'b0, 1'b1, 0, 0);
    total++;
    if (dist_sq !== 16'd65535) begin
      bad++;
      $display("FAIL x256_sat: dist_sq=%0d, required 65535", dist_sq);
    end
  endtask

  task automatic test_far_centre();
    int n;
    cycle(1'b1, 1'b0, 1'b0, 320, 240);
    wait_calc(n);
    total++;
    if (dist_sq !== 16'd65535) begin
      bad++;
      $display("FAIL origin_sat: dist_sq=%0d, required 65535", dist_sq);
    end
    for (int i = 0; i < 240; i++) cycle(1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 320; i++) cycle(1'b0, 1'b0, 1'b1, 0, 0);
    total++;
    if (dist_sq !== 16'd0) begin
      bad++;
      $display("FAIL at_centre: dist_sq=%0d, required 0", dist_sq);
    end
    cycle(1'b0, 1'b0, 1'b1, 0, 0);
    total++;
    if (dist_sq !== 16'd1) begin
      bad++;
      $display("FAIL past_centre: dist_sq=%0d, required 1", dist_sq);
    end
  endtask

  task automatic test_restart();
    int n;
    cycle(1'b1, 1'b0, 1'b0, 100, 100);
    idle(7);
    cycle(1'b1, 1'b0, 1'b0, 5, 0);
    wait_calc(n);
    total++;
    if (n != CALC_CYCLES) begin
      bad++;
      $display("FAIL restart_busy: got %0d cycles, required %0d", n, CALC_CYCLES);
    end
    total++;
    if (dist_sq !== 16'd25 || dist_valid !== 1'b1) begin
      bad++;
      $display("FAIL restart_origin: dist_sq=%0d valid=%b, required 25/1", dist_sq, dist_valid);
    end
    total++;
    if (isqrt(int'(dist_sq)) != 5) begin
      bad++;
      $display("FAIL sqrt_out: got %0d, required 5", isqrt(int'(dist_sq)));
    end
  endtask

  task automatic test_random();
    int n, rcx, rcy;
    bit le, pe;
    for (int f = 0; f < 4; f++) begin
      rcx = int'($urandom_range(639, 0));
      rcy = int'($urandom_range(479, 0));
      cycle(1'b1, 1'b0, 1'b0, rcx, rcy);
      wait_calc(n);
      total++;
      if (n != CALC_CYCLES || dist_valid !== 1'b1) begin
        bad++;
        $display("FAIL rand_calc f%0d: busy %0d cycles valid=%b, required %0d/1", f, n, dist_valid, CALC_CYCLES);
      end
      for (int i = 0; i < 400; i++) begin
        le = ($urandom_range(15, 0) == 0) || (m_x >= 700);
        pe = ($urandom_range(3, 0) != 0);
        // Centre inputs wiggle freely; they must be ignored outside frame_start.
        cycle(1'b0, le, pe, int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)));
        total++;
        if (dist_sq !== 16'(exp_dist()) || dist_valid !== 1'b1 || busy !== 1'b0) begin
          bad++;
          $display("FAIL rand f%0d c%0d x=%0d y=%0d: dist_sq=%0d valid=%b busy=%b, required %0d/1/0",
                   f, i, m_x, m_y, dist_sq, dist_valid, busy, exp_dist());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_line_end();
    test_saturation();
    test_far_centre();
    test_restart();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
